// File: rtl/pusch_rx_demapper.sv
// ---------------------------------------------------------------------------
// pusch_rx_demapper
//
// Hard-decision QAM demapper (BPSK / QPSK / 16QAM / 64QAM). Accepts one
// equalised complex sample per handshake, decides its Qm bits and
// re-serialises them one bit per clock, b0 first, towards the descrambler.
//
// Ports
//   CLK         clock
//   RST         asynchronous active-low reset
//   Demap_IN_I  signed in-phase sample, Q.16
//   Demap_IN_Q  signed quadrature sample, Q.16
//   Valid_IN    sample valid
//   Order_IN    modulation order Qm (1, 2, 4, 6 legal)
//   Ready_OUT   sample can be accepted this cycle
//   Serial_OUT  decided bit
//   Valid_OUT   Serial_OUT valid
//   Err_OUT     one-cycle pulse after a sample with an illegal order
//   Bit_Count   bits emitted since reset, wraps at 2^17
// ---------------------------------------------------------------------------
module pusch_rx_demapper #(
    parameter int WIDTH     = 18,
    parameter int THR_16    = 41449,
    parameter int THR_64_2A = 20225,
    parameter int THR_64_4A = 40450
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic signed [WIDTH-1:0] Demap_IN_I,
    input  logic signed [WIDTH-1:0] Demap_IN_Q,
    input  logic                    Valid_IN,
    input  logic [2:0]              Order_IN,
    output logic                    Ready_OUT,
    output logic                    Serial_OUT,
    output logic                    Valid_OUT,
    output logic                    Err_OUT,
    output logic [16:0]             Bit_Count
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // Thresholds at the magnitude width so every compare is unsigned and exact.
    localparam logic [WIDTH:0] L_THR_16    = THR_16[WIDTH:0];
    localparam logic [WIDTH:0] L_THR_64_2A = THR_64_2A[WIDTH:0];
    localparam logic [WIDTH:0] L_THR_64_4A = THR_64_4A[WIDTH:0];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_shift;
    logic [2:0]      r_count;
    logic [16:0]     r_bit_count;
    logic            r_err;

    logic            w_neg_i;
    logic            w_neg_q;
    logic [WIDTH:0]  w_ext_i;
    logic [WIDTH:0]  w_ext_q;
    logic [WIDTH:0]  w_abs_i;
    logic [WIDTH:0]  w_abs_q;
    logic [WIDTH:0]  w_dist_i;
    logic [WIDTH:0]  w_dist_q;
    logic [5:0]      w_bits;
    logic            w_legal;
    logic            w_accept;
    logic            w_load;

    // -----------------------------------------------------------------------
    // Decision logic. One extra bit of magnitude keeps |-2^(WIDTH-1)| exact.
    // -----------------------------------------------------------------------
    assign w_neg_i  = Demap_IN_I[WIDTH-1];
    assign w_neg_q  = Demap_IN_Q[WIDTH-1];
    assign w_ext_i  = {w_neg_i, Demap_IN_I};
    assign w_ext_q  = {w_neg_q, Demap_IN_Q};
    assign w_abs_i  = w_neg_i ? -w_ext_i : w_ext_i;
    assign w_abs_q  = w_neg_q ? -w_ext_q : w_ext_q;

    // Distance from the 64QAM mid level, folded so it is never negative.
    assign w_dist_i = (w_abs_i > L_THR_64_4A) ? (w_abs_i - L_THR_64_4A) : (L_THR_64_4A - w_abs_i);
    assign w_dist_q = (w_abs_q > L_THR_64_4A) ? (w_abs_q - L_THR_64_4A) : (L_THR_64_4A - w_abs_q);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_bits  = '0;
        w_legal = 1'b1;
        case (Order_IN)
            3'd1: begin
                w_bits[0] = w_neg_i;
            end
            3'd2: begin
                w_bits[0] = w_neg_i;
                w_bits[1] = w_neg_q;
            end
            3'd4: begin
                w_bits[0] = w_neg_i;
                w_bits[1] = w_neg_q;
                w_bits[2] = w_abs_i > L_THR_16;
                w_bits[3] = w_abs_q > L_THR_16;
            end
            3'd6: begin
                w_bits[0] = w_neg_i;
                w_bits[1] = w_neg_q;
                w_bits[2] = w_abs_i > L_THR_64_4A;
                w_bits[3] = w_abs_q > L_THR_64_4A;
                w_bits[4] = w_dist_i > L_THR_64_2A;
                w_bits[5] = w_dist_q > L_THR_64_2A;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready is raised during the last bit so the next symbol follows with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        Ready_OUT   = 1'b0;
        Valid_OUT   = 1'b0;
        case (r_state)
            S_IDLE: begin
                Ready_OUT = 1'b1;
                if (Valid_IN && w_legal) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                Valid_OUT = 1'b1;
                if (r_count == 3'd1) begin
                    Ready_OUT = 1'b1;
                    if (!(Valid_IN && w_legal)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = Valid_IN && Ready_OUT;
    assign w_load   = w_accept && w_legal;

    // -----------------------------------------------------------------------
    // Shift register, bit counter, error pulse
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift     <= '0;
            r_count     <= '0;
            r_bit_count <= '0;
            r_err       <= 1'b0;
        end else begin
            // An illegal order consumes the sample and only flags it.
            r_err <= w_accept && !w_legal;
            if (Valid_OUT) begin
                r_bit_count <= r_bit_count + 17'd1;
            end
            if (w_load) begin
                r_shift <= w_bits;
                r_count <= Order_IN;
            end else if (Valid_OUT) begin
                r_shift <= r_shift >> 1;
                r_count <= r_count - 3'd1;
            end
        end
    end

    assign Serial_OUT = Valid_OUT && r_shift[0];
    assign Err_OUT    = r_err;
    assign Bit_Count  = r_bit_count;

endmodule

// File: tb/tb_pusch_rx_demapper.sv
// ---------------------------------------------------------------------------
// tb_pusch_rx_demapper
//
// Directed bench for pusch_rx_demapper: reset (including mid-symbol),
// QPSK back-to-back streaming, 16QAM with threshold boundary, all 64QAM
// amplitude levels, the most negative input, BPSK, illegal order and
// order changes while a symbol is being serialised.
// ---------------------------------------------------------------------------
module tb_pusch_rx_demapper;

    logic               clk;
    logic               rst;
    logic signed [17:0] din_i;
    logic signed [17:0] din_q;
    logic               valid_in;
    logic [2:0]         ord_in;
    logic               ready;
    logic               serial;
    logic               valid_out;
    logic               err;
    logic [16:0]        bit_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_total = 0;

    pusch_rx_demapper dut (
        .CLK        (clk),
        .RST        (rst),
        .Demap_IN_I (din_i),
        .Demap_IN_Q (din_q),
        .Valid_IN   (valid_in),
        .Order_IN   (ord_in),
        .Ready_OUT  (ready),
        .Serial_OUT (serial),
        .Valid_OUT  (valid_out),
        .Err_OUT    (err),
        .Bit_Count  (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample when the DUT is ready, then disturb inputs (order
    // included) and check the serial bits, ready timing and final count.
    task automatic run_symbol(input string tag, input logic signed [17:0] i,
                              input logic signed [17:0] q, input logic [2:0] ord,
                              input logic [5:0] exp_bits, input int n);
        int waited = 0;
        while (!ready && waited < 20) begin
            tick();
            waited++;
        end
        check($sformatf("%s ready_before", tag), ready, 1);
        din_i    = i;
        din_q    = q;
        ord_in   = ord;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        ord_in   = ~ord;
        din_i    = ~i;
        din_q    = ~q;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s valid b%0d", tag, k), valid_out, 1);
            check($sformatf("%s bit b%0d", tag, k), serial, exp_bits[k]);
            check($sformatf("%s ready b%0d", tag, k), ready, (k == n - 1) ? 1 : 0);
            tick();
        end
        check($sformatf("%s valid_after", tag), valid_out, 0);
        exp_total += n;
        check($sformatf("%s bit_count", tag), bit_count, exp_total);
    endtask

    initial begin
        int seen;
        rst      = 1'b0;
        din_i    = '0;
        din_q    = '0;
        valid_in = 1'b0;
        ord_in   = 3'd0;

        // Reset state
        tick();
        tick();
        check("rst ready", ready, 1);
        check("rst serial", serial, 0);
        check("rst valid", valid_out, 0);
        check("rst err", err, 0);
        check("rst bit_count", bit_count, 0);
        rst = 1'b1;
        tick();

        // Reset mid-symbol: 64QAM sample, reset during its first bit
        din_i    = -18'sd131072;
        din_q    = 18'sd10112;
        ord_in   = 3'd6;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("midrst valid", valid_out, 1);
        check("midrst bit0", serial, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst async ready", ready, 1);
        check("midrst async valid", valid_out, 0);
        check("midrst async serial", serial, 0);
        check("midrst async bit_count", bit_count, 0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (valid_out) seen++;
            tick();
        end
        check("midrst no_more_bits", seen, 0);
        check("midrst bit_count", bit_count, 0);
        check("midrst err", err, 0);

        // QPSK back-to-back: (+,-) then (-,+) -> 0,1,1,0
        din_i    = 18'sd46341;
        din_q    = -18'sd46341;
        ord_in   = 3'd2;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        ord_in   = 3'd6;
        check("qpsk c0 valid", valid_out, 1);
        check("qpsk c0 bit", serial, 0);
        check("qpsk c0 ready", ready, 0);
        tick();
        check("qpsk c1 valid", valid_out, 1);
        check("qpsk c1 bit", serial, 1);
        check("qpsk c1 ready", ready, 1);
        din_i    = -18'sd46341;
        din_q    = 18'sd46341;
        ord_in   = 3'd2;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        ord_in   = 3'd4;
        check("qpsk c2 valid", valid_out, 1);
        check("qpsk c2 bit", serial, 1);
        check("qpsk c2 ready", ready, 0);
        tick();
        check("qpsk c3 valid", valid_out, 1);
        check("qpsk c3 bit", serial, 0);
        check("qpsk c3 ready", ready, 1);
        tick();
        check("qpsk end valid", valid_out, 0);
        check("qpsk bit_count", bit_count, 4);
        exp_total = 4;

        // 16QAM (order is disturbed after accept inside run_symbol)
        run_symbol("16qam", -18'sd62172, 18'sd20724, 3'd4, 6'b000101, 4);
        run_symbol("16qam_thr", 18'sd41449, 18'sd20724, 3'd4, 6'b000000, 4);

        // 64QAM: I amplitudes 1,3,5,7 x 10112, Q = +10112
        run_symbol("64qam_a1", 18'sd10112, 18'sd10112, 3'd6, 6'b110000, 6);
        run_symbol("64qam_a3", 18'sd30336, 18'sd10112, 3'd6, 6'b100000, 6);
        run_symbol("64qam_a5", 18'sd50560, 18'sd10112, 3'd6, 6'b100100, 6);
        run_symbol("64qam_a7", 18'sd70784, 18'sd10112, 3'd6, 6'b110100, 6);
        run_symbol("64qam_min", -18'sd131072, 18'sd10112, 3'd6, 6'b110101, 6);

        // BPSK: zero counts as positive
        run_symbol("bpsk_neg", -18'sd5, 18'sd0, 3'd1, 6'b000001, 1);
        run_symbol("bpsk_zero", 18'sd0, -18'sd7, 3'd1, 6'b000000, 1);

        // Illegal order
        din_i    = -18'sd1000;
        din_q    = -18'sd1000;
        ord_in   = 3'd3;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("illegal err", err, 1);
        check("illegal valid", valid_out, 0);
        check("illegal ready", ready, 1);
        tick();
        check("illegal err_clear", err, 0);
        check("illegal valid2", valid_out, 0);
        check("illegal bit_count", bit_count, exp_total);
        run_symbol("after_illegal", -18'sd46341, -18'sd46341, 3'd2, 6'b000011, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pusch_rx_demapper.md
Name: pusch_rx_demapper

Overview:
- Hard-decision QAM demapper for the receive chain; the inverse of the transmit modulation mapper.
- Takes one equalised complex sample (I/Q, signed fixed-point) per handshake and re-serialises its Qm decided bits, one bit per clock, to the descrambler.
- Sits between the receive FFT/equaliser memory read-out and the descrambler.
- Bit order and constellation follow TS 38.211 section 5.1: BPSK, QPSK, 16QAM, 64QAM.

Parameters:
- WIDTH, 18, I/Q sample width (signed, 16 fractional bits).
- THR_16, 41449, 16QAM decision threshold 2/sqrt(10) in Q.16.
- THR_64_2A, 20225, 64QAM threshold 2/sqrt(42) in Q.16.
- THR_64_4A, 40450, 64QAM threshold 4/sqrt(42) in Q.16.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- Demap_IN_I  in  WIDTH  signed in-phase sample.
- Demap_IN_Q  in  WIDTH  signed quadrature sample.
- Valid_IN  in  1  sample valid.
- Order_IN  in  3  modulation order Qm: 1, 2, 4 or 6.
- Ready_OUT  out  1  demapper can accept a sample this cycle.
- Serial_OUT  out  1  decided bit.
- Valid_OUT  out  1  Serial_OUT valid.
- Err_OUT  out  1  one-cycle pulse: sample accepted with an illegal order.
- Bit_Count  out  17  total bits emitted since reset, wraps at 2^17.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; Ready_OUT=1; Serial_OUT=0, Valid_OUT=0, Err_OUT=0, Bit_Count=0.
  - Shift register and bit counter cleared.
  - Reset mid-symbol discards the remaining bits of that symbol.
- Accept: a sample is taken on the rising edge when Valid_IN && Ready_OUT. Order_IN is sampled at the same edge. Order changes at any other time are ignored.
- Decision (combinational on the inputs, registered at accept):
  - aI=|I| and aQ=|Q| computed in WIDTH+1 bits, so the most negative input is exact. Zero counts as positive. Comparisons are strict (>), so a value equal to a threshold decides "not greater".
  - Qm=1: b0 = I<0.
  - Qm=2: b0 = I<0, b1 = Q<0.
  - Qm=4: b0 = I<0, b1 = Q<0, b2 = aI>THR_16, b3 = aQ>THR_16.
  - Qm=6: b0 = I<0, b1 = Q<0, b2 = aI>THR_64_4A, b3 = aQ>THR_64_4A.
  - Qm=6 (cont.): b4 = |aI-THR_64_4A|>THR_64_2A, b5 = |aQ-THR_64_4A|>THR_64_2A.
- States:
  - IDLE: Ready_OUT=1, Valid_OUT=0.
    - Accept with a legal Qm -> load shift register {b(Qm-1)..b0}, set count=Qm, go SHIFT.
    - Accept with an illegal Qm (0,3,5,7) -> sample consumed, no bits emitted, Err_OUT=1 for the next cycle, stay IDLE.
  - SHIFT: each cycle drives Serial_OUT=b[k] with Valid_OUT=1, b0 first. Bit_Count increments by 1 per valid bit. count decrements.
    - Ready_OUT=1 only during the last bit (count==1), giving back-to-back streaming with no bubble.
    - Accept during the last bit -> reload and stay SHIFT.
    - No accept during the last bit -> go IDLE.
- Latency: the first bit of a symbol appears the cycle after acceptance.
- Throughput: one symbol per Qm cycles.
- No downstream back-pressure: the descrambler always accepts a valid bit.
- Valid_IN is held off while Ready_OUT=0; the source holds its sample until accepted.

Test Plan:
- Reset mid-symbol: Qm=6 sample accepted, RST low 1 cycle after -> all outputs 0, Ready_OUT=1, no further bits.
- QPSK stream: Qm=2, samples (+46341,-46341), (-46341,+46341) back-to-back -> Serial_OUT 0,1,1,0 on 4 consecutive cycles; Ready_OUT high on cycles 1 and 3 only; Bit_Count=4.
- 16QAM: I=-3*20724=-62172, Q=+20724 -> bits 1,0,1,0. Boundary: I=+41449 (equal to THR_16) -> b2=0.
- 64QAM, all four I amplitudes {1,3,5,7}*10112 with Q=+10112 -> (b2,b4) = (0,1),(0,0),(1,0),(1,1). Q bits: b1=0, b3=0, b5=1. Also I=-131072 decides b0=1, b2=1, b4=1 with no overflow.
- Illegal order: Qm=3 with Valid_IN -> Err_OUT one-cycle pulse, Valid_OUT stays 0, Bit_Count unchanged, next legal sample processed normally.
- Order change while Ready_OUT=0 during a Qm=4 symbol -> the current symbol still emits exactly 4 bits.
